w0rm_mem_arbiter: RTL and testbench

- Two-requester front end that sits directly upstream of the single-port memory block.
- Arbitrates between requester 0 (fetch) and requester 1 (load/store), and drives the memory block's port A request signals.
- Tags each request with the requester ID in the memory user field, then routes the echoed response back to the requester that issued it.
- The memory gives no response for out-of-range addresses, so each requester has a response timeout that returns an error completion instead of hanging.

---
 rtl/w0rm_mem_arbiter.sv | 188 ++++++++++++++++++
 tb/tb_w0rm_mem_arbiter.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/w0rm_mem_arbiter.sv
// Two-requester arbiter in front of the single-port memory: tags requests with the
// requester ID, routes echoed responses back, and times out unanswered requests.
module w0rm_mem_arbiter #(
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 32,
    parameter int USER_WIDTH   = 32,
    parameter int RESP_TIMEOUT = 16
) (
    input  logic                  mem_clk,
    input  logic                  mem_reset,

    input  logic                  m0_valid_i,
    output logic                  m0_ready_o,
    input  logic                  m0_read_i,
    input  logic                  m0_write_i,
    input  logic [ADDR_WIDTH-1:0] m0_addr_i,
    input  logic [DATA_WIDTH-1:0] m0_data_i,
    input  logic [USER_WIDTH-1:0] m0_user_i,
    output logic                  m0_valid_o,
    output logic [DATA_WIDTH-1:0] m0_data_o,
    output logic [USER_WIDTH-1:0] m0_user_o,
    output logic                  m0_error_o,

    input  logic                  m1_valid_i,
    output logic                  m1_ready_o,
    input  logic                  m1_read_i,
    input  logic                  m1_write_i,
    input  logic [ADDR_WIDTH-1:0] m1_addr_i,
    input  logic [DATA_WIDTH-1:0] m1_data_i,
    input  logic [USER_WIDTH-1:0] m1_user_i,
    output logic                  m1_valid_o,
    output logic [DATA_WIDTH-1:0] m1_data_o,
    output logic [USER_WIDTH-1:0] m1_user_o,
    output logic                  m1_error_o,

    output logic                  mem_valid_o,
    output logic                  mem_read_o,
    output logic                  mem_write_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [DATA_WIDTH-1:0] mem_data_o,
    output logic [USER_WIDTH:0]   mem_user_o,
    input  logic                  mem_valid_i,
    input  logic [DATA_WIDTH-1:0] mem_data_i,
    input  logic [USER_WIDTH:0]   mem_user_i
);

    localparam int CNT_W = $clog2(RESP_TIMEOUT);
    // Counter reads 0 in the first WAIT cycle, so the error pulse lands RESP_TIMEOUT cycles after accept.
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(RESP_TIMEOUT - 2);

    typedef enum logic {S_IDLE, S_WAIT} state_t;

    state_t                state_q [2];
    state_t                state_d [2];
    logic [CNT_W-1:0]      cnt_q   [2];
    logic [USER_WIDTH-1:0] tag_q   [2];
    logic [USER_WIDTH-1:0] req_user[2];
    logic                  last_grant;
    logic [1:0]            req_valid, elig, grant, rsp_hit, tmo_hit;
    logic [1:0]            cmp_valid_q, cmp_error_q;
    logic [DATA_WIDTH-1:0] cmp_data_q [2];
    logic [USER_WIDTH-1:0] cmp_user_q [2];
    logic                  unused_user;

    assign req_valid   = {m1_valid_i, m0_valid_i};
    assign req_user[0] = m0_user_i;
    assign req_user[1] = m1_user_i;
    // Only the ID bit routes a response; the echoed tag bits are not needed.
    assign unused_user = ^mem_user_i[USER_WIDTH-1:0];

    always_ff @(posedge mem_clk) begin
        if (mem_reset) begin
            state_q[0] <= S_IDLE;
            state_q[1] <= S_IDLE;
        end else begin
            state_q[0] <= state_d[0];
            state_q[1] <= state_d[1];
        end
    end

    always_comb begin
        rsp_hit = '0;
        tmo_hit = '0;
        for (int unsigned i = 0; i < 2; i++) begin
            rsp_hit[i] = (state_q[i] == S_WAIT) && mem_valid_i && (mem_user_i[USER_WIDTH] == 1'(i));
            tmo_hit[i] = (state_q[i] == S_WAIT) && (cnt_q[i] == TMO_LAST);
            state_d[i] = state_q[i];
            case (state_q[i])
                S_IDLE:  if (grant[i]) state_d[i] = S_WAIT;
                S_WAIT:  if (rsp_hit[i] || tmo_hit[i]) state_d[i] = S_IDLE;
                default: state_d[i] = S_IDLE;
            endcase
        end
    end

    always_comb begin
        elig  = '0;
        grant = '0;
        for (int unsigned i = 0; i < 2; i++) begin
            elig[i] = (state_q[i] == S_IDLE) && req_valid[i];
        end
        grant[0] = elig[0] && (!elig[1] || last_grant);
        grant[1] = elig[1] && (!elig[0] || !last_grant);
    end

    assign m0_ready_o = grant[0];
    assign m1_ready_o = grant[1];

    always_ff @(posedge mem_clk) begin
        if (mem_reset) begin
            last_grant <= 1'b1;
            for (int unsigned i = 0; i < 2; i++) begin
                cnt_q[i] <= '0;
                tag_q[i] <= '0;
            end
        end else begin
            if (&elig) last_grant <= grant[1];
            for (int unsigned i = 0; i < 2; i++) begin
                if (grant[i]) begin
                    cnt_q[i] <= '0;
                    tag_q[i] <= req_user[i];
                end else if (state_q[i] == S_WAIT) begin
                    cnt_q[i] <= cnt_q[i] + CNT_W'(1);
                end
            end
        end
    end

    // A response in the timeout cycle takes precedence and completes without error.
    always_ff @(posedge mem_clk) begin
        if (mem_reset) begin
            cmp_valid_q <= '0;
            cmp_error_q <= '0;
            for (int unsigned i = 0; i < 2; i++) begin
                cmp_data_q[i] <= '0;
                cmp_user_q[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < 2; i++) begin
                cmp_valid_q[i] <= rsp_hit[i] | tmo_hit[i];
                cmp_error_q[i] <= tmo_hit[i] & ~rsp_hit[i];
                if (rsp_hit[i]) begin
                    cmp_data_q[i] <= mem_data_i;
                    cmp_user_q[i] <= tag_q[i];
                end else if (tmo_hit[i]) begin
                    cmp_data_q[i] <= '0;
                    cmp_user_q[i] <= tag_q[i];
                end
            end
        end
    end

    assign m0_valid_o = cmp_valid_q[0];
    assign m0_error_o = cmp_error_q[0];
    assign m0_data_o  = cmp_data_q[0];
    assign m0_user_o  = cmp_user_q[0];
    assign m1_valid_o = cmp_valid_q[1];
    assign m1_error_o = cmp_error_q[1];
    assign m1_data_o  = cmp_data_q[1];
    assign m1_user_o  = cmp_user_q[1];

    always_ff @(posedge mem_clk) begin
        if (mem_reset) begin
            mem_valid_o <= 1'b0;
            mem_read_o  <= 1'b0;
            mem_write_o <= 1'b0;
            mem_addr_o  <= '0;
            mem_data_o  <= '0;
            mem_user_o  <= '0;
        end else begin
            mem_valid_o <= |grant;
            if (grant[0]) begin
                mem_read_o  <= m0_read_i;
                mem_write_o <= m0_write_i;
                mem_addr_o  <= m0_addr_i;
                mem_data_o  <= m0_data_i;
                mem_user_o  <= {1'b0, m0_user_i};
            end else if (grant[1]) begin
                mem_read_o  <= m1_read_i;
                mem_write_o <= m1_write_i;
                mem_addr_o  <= m1_addr_i;
                mem_data_o  <= m1_data_i;
                mem_user_o  <= {1'b1, m1_user_i};
            end
        end
    end

endmodule

// File: tb/tb_w0rm_mem_arbiter.sv
// Scoreboard bench for w0rm_mem_arbiter: directed requests push expected memory
// requests and completions; a negedge monitor pops and compares them.
module tb_w0rm_mem_arbiter;

    localparam int RT = 16;

    logic        mem_clk = 1'b0;
    logic        mem_reset = 1'b1;
    logic        m0_valid_i = 1'b0, m0_read_i = 1'b0, m0_write_i = 1'b0;
    logic [31:0] m0_addr_i = '0, m0_data_i = '0, m0_user_i = '0;
    logic        m1_valid_i = 1'b0, m1_read_i = 1'b0, m1_write_i = 1'b0;
    logic [31:0] m1_addr_i = '0, m1_data_i = '0, m1_user_i = '0;
    logic        m0_ready_o, m0_valid_o, m0_error_o, m1_ready_o, m1_valid_o, m1_error_o;
    logic [31:0] m0_data_o, m0_user_o, m1_data_o, m1_user_o;
    logic        mem_valid_o, mem_read_o, mem_write_o;
    logic [31:0] mem_addr_o, mem_data_o;
    logic [32:0] mem_user_o;
    logic        mem_valid_i = 1'b0;
    logic [31:0] mem_data_i = '0;
    logic [32:0] mem_user_i = '0;

    w0rm_mem_arbiter #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .USER_WIDTH(32), .RESP_TIMEOUT(RT)
    ) dut (
        .mem_clk(mem_clk), .mem_reset(mem_reset),
        .m0_valid_i(m0_valid_i), .m0_ready_o(m0_ready_o), .m0_read_i(m0_read_i),
        .m0_write_i(m0_write_i), .m0_addr_i(m0_addr_i), .m0_data_i(m0_data_i),
        .m0_user_i(m0_user_i), .m0_valid_o(m0_valid_o), .m0_data_o(m0_data_o),
        .m0_user_o(m0_user_o), .m0_error_o(m0_error_o),
        .m1_valid_i(m1_valid_i), .m1_ready_o(m1_ready_o), .m1_read_i(m1_read_i),
        .m1_write_i(m1_write_i), .m1_addr_i(m1_addr_i), .m1_data_i(m1_data_i),
        .m1_user_i(m1_user_i), .m1_valid_o(m1_valid_o), .m1_data_o(m1_data_o),
        .m1_user_o(m1_user_o), .m1_error_o(m1_error_o),
        .mem_valid_o(mem_valid_o), .mem_read_o(mem_read_o), .mem_write_o(mem_write_o),
        .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o), .mem_user_o(mem_user_o),
        .mem_valid_i(mem_valid_i), .mem_data_i(mem_data_i), .mem_user_i(mem_user_i)
    );

    initial forever #5 mem_clk = ~mem_clk;

    int cyc = 0;
    initial forever begin
        @(posedge mem_clk);
        cyc++;
    end

    int checks = 0;
    int errors = 0;

    typedef struct { logic [31:0] data; logic [31:0] user; logic err; int cyc; } cmp_t;
    typedef struct { logic [31:0] addr; logic [31:0] data; logic rd; logic wr; logic [32:0] user; int cyc; } mreq_t;

    cmp_t  exp0[$];
    cmp_t  exp1[$];
    mreq_t expm[$];
    logic  busy1 = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic pop_cmp(input int n, input logic [31:0] d, input logic [31:0] u, input logic er);
        cmp_t e;
        if ((n == 0 && exp0.size() == 0) || (n == 1 && exp1.size() == 0)) begin
            checks++;
            errors++;
            $display("FAIL m%0d_unexpected_completion: got valid_o=1 data 0x%0h err %0d, expected no completion (cycle %0d)",
                     n, d, er, cyc);
            return;
        end
        if (n == 0) e = exp0.pop_front();
        else begin
            e = exp1.pop_front();
            busy1 = 1'b0;
        end
        chk($sformatf("m%0d_data", n), d, e.data);
        chk($sformatf("m%0d_user", n), u, e.user);
        chk($sformatf("m%0d_error", n), er, e.err);
        chk($sformatf("m%0d_cmp_cycle", n), cyc, e.cyc);
    endtask

    // Monitor: compares everything the DUT presents against the scoreboard queues.
    initial begin
        mreq_t m;
        forever begin
            @(negedge mem_clk);
            if (m0_valid_o) pop_cmp(0, m0_data_o, m0_user_o, m0_error_o);
            if (m1_valid_o) pop_cmp(1, m1_data_o, m1_user_o, m1_error_o);
            if (mem_valid_o) begin
                if (expm.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL mem_unexpected_request: got mem_valid_o=1 addr 0x%0h, expected none (cycle %0d)",
                             mem_addr_o, cyc);
                end else begin
                    m = expm.pop_front();
                    chk("mem_addr", mem_addr_o, m.addr);
                    chk("mem_data", mem_data_o, m.data);
                    chk("mem_read", mem_read_o, m.rd);
                    chk("mem_write", mem_write_o, m.wr);
                    chk("mem_user", mem_user_o, m.user);
                    chk("mem_cycle", cyc, m.cyc);
                end
            end
            if (busy1) chk("m1_ready_while_wait", m1_ready_o, 0);
        end
    end

    // Memory model: answers in-range (0x4xxx_xxxx) reads/writes one cycle after the request.
    logic [31:0] words [logic [31:0]];
    logic        auto_en = 1'b1;
    logic        pend_v = 1'b0;
    logic [31:0] pend_d = '0;
    logic [32:0] pend_u = '0;
    initial forever begin
        @(posedge mem_clk);
        #1;
        if (auto_en) begin
            mem_valid_i = pend_v;
            mem_data_i  = pend_d;
            mem_user_i  = pend_u;
            pend_v = 1'b0;
            if (mem_valid_o && mem_addr_o[31:28] == 4'h4 && (mem_read_o || mem_write_o)) begin
                pend_v = 1'b1;
                pend_u = mem_user_o;
                if (mem_write_o) begin
                    words[mem_addr_o] = mem_data_o;
                    pend_d = '0;
                end else begin
                    pend_d = words.exists(mem_addr_o) ? words[mem_addr_o] : 32'h0;
                end
            end
        end else begin
            pend_v = 1'b0;
        end
    end

    task automatic drive(input int n, input logic v, input logic rd, input logic wr,
                         input logic [31:0] a, input logic [31:0] d, input logic [31:0] u);
        if (n == 0) begin
            m0_valid_i = v; m0_read_i = rd; m0_write_i = wr; m0_addr_i = a; m0_data_i = d; m0_user_i = u;
        end else begin
            m1_valid_i = v; m1_read_i = rd; m1_write_i = wr; m1_addr_i = a; m1_data_i = d; m1_user_i = u;
        end
    endtask

    // Called at posedge+1; returns at posedge+1 of the cycle after acceptance.
    task automatic req(input int n, input logic rd, input logic wr, input logic [31:0] a,
                       input logic [31:0] d, input logic [31:0] u, input logic exp_cmp,
                       input logic [31:0] edata, input logic eerr, input int lat,
                       input logic hold, output int acc);
        mreq_t m;
        cmp_t  c;
        bit    got = 0;
        acc = -1;
        drive(n, 1'b1, rd, wr, a, d, u);
        for (int k = 0; k < 64 && !got; k++) begin
            @(negedge mem_clk);
            if ((n == 0) ? m0_ready_o : m1_ready_o) begin
                got = 1;
                acc = cyc;
                m.addr = a; m.data = d; m.rd = rd; m.wr = wr; m.user = {n[0], u}; m.cyc = cyc + 1;
                expm.push_back(m);
                if (exp_cmp) begin
                    c.data = edata; c.user = u; c.err = eerr; c.cyc = cyc + lat;
                    if (n == 0) exp0.push_back(c);
                    else exp1.push_back(c);
                end
            end
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL m%0d_accept: got no ready within 64 cycles, expected acceptance", n);
        end
        @(posedge mem_clk);
        #1;
        if (!hold) drive(n, 1'b0, 1'b0, 1'b0, '0, '0, '0);
        if (got && n == 1) busy1 = exp_cmp;
    endtask

    task automatic step(input int k);
        repeat (k) begin
            @(posedge mem_clk);
            #1;
        end
    endtask

    initial begin
        int a0, a1, a0b, acc, start;
        words[32'h4000_0000] = 32'h1111_0000;
        words[32'h4000_0004] = 32'h2222_0004;
        words[32'h4000_0008] = 32'h1234_5678;

        // Reset state
        repeat (2) @(posedge mem_clk);
        @(negedge mem_clk);
        chk("rst_m0_ready", m0_ready_o, 0);
        chk("rst_m1_ready", m1_ready_o, 0);
        chk("rst_mem_valid", mem_valid_o, 0);
        chk("rst_mem_user", mem_user_o, 0);
        chk("rst_mem_addr", mem_addr_o, 0);
        chk("rst_m0_valid", m0_valid_o, 0);
        chk("rst_m1_valid", m1_valid_o, 0);
        chk("rst_m0_data", m0_data_o, 0);
        chk("rst_m1_user", m1_user_o, 0);
        chk("rst_m1_error", m1_error_o, 0);
        @(posedge mem_clk);
        #1;
        mem_reset = 1'b0;
        step(1);

        // Both valid after reset: m0, then m1, then m0 again
        fork
            begin
                req(0, 1, 0, 32'h4000_0000, 0, 32'h10, 1, 32'h1111_0000, 0, 3, 1, a0);
                req(0, 1, 0, 32'h4000_0008, 0, 32'h12, 1, 32'h1234_5678, 0, 3, 0, a0b);
            end
            req(1, 1, 0, 32'h4000_0004, 0, 32'h21, 1, 32'h2222_0004, 0, 3, 0, a1);
        join
        chk("grant_order_m1", a1, a0 + 1);
        chk("grant_order_m0_again", a0b, a0 + 3);
        step(6);

        // Basic m0 read
        req(0, 1, 0, 32'h4000_0008, 0, 32'hA5, 1, 32'h1234_5678, 0, 3, 0, acc);
        step(4);

        // m1 out-of-range read times out; late response is dropped
        req(1, 1, 0, 32'h0000_0000, 0, 32'h77, 1, 32'h0, 1, RT, 0, acc);
        step(RT + 1);
        auto_en = 1'b0;
        mem_valid_i = 1'b1; mem_data_i = 32'hFFFF_FFFF; mem_user_i = {1'b1, 32'h77};
        step(1);
        mem_valid_i = 1'b0;
        step(3);

        // Response in the exact timeout cycle wins over the error
        req(0, 1, 0, 32'h0000_0010, 0, 32'h3C, 1, 32'hCAFE_F00D, 0, RT, 0, acc);
        while (cyc < acc + RT - 1) step(1);
        mem_valid_i = 1'b1; mem_data_i = 32'hCAFE_F00D; mem_user_i = {1'b0, 32'h3C};
        step(1);
        mem_valid_i = 1'b0;
        step(RT + 2);

        // Reset while m0 waits: no completion, stale response dropped, m0 ready again
        req(0, 1, 0, 32'h4000_0008, 0, 32'h11, 0, 32'h0, 0, 3, 0, acc);
        mem_reset = 1'b1;
        step(1);
        mem_reset = 1'b0;
        mem_valid_i = 1'b1; mem_data_i = 32'h0000_0099; mem_user_i = {1'b0, 32'h11};
        step(1);
        mem_valid_i = 1'b0;
        auto_en = 1'b1;
        start = cyc;
        req(0, 1, 0, 32'h4000_0000, 0, 32'h12, 1, 32'h1111_0000, 0, 3, 0, acc);
        chk("m0_ready_after_reset", acc, start);
        step(4);

        // m1 write then read-back
        req(1, 0, 1, 32'h4000_0010, 32'hDEAD_BEEF, 32'h05, 1, 32'h0, 0, 3, 0, acc);
        step(4);
        req(1, 1, 0, 32'h4000_0010, 0, 32'h06, 1, 32'hDEAD_BEEF, 0, 3, 0, acc);
        step(4);

        // Neither read nor write: forwarded, completes by timeout
        req(0, 0, 0, 32'h4000_0000, 32'h55, 32'h0F, 1, 32'h0, 1, RT, 0, acc);
        step(RT + 4);

        chk("exp0_drained", exp0.size(), 0);
        chk("exp1_drained", exp1.size(), 0);
        chk("expm_drained", expm.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
